// File: rtl/pc_gen_if.sv
// Fetch-PC request/response bundle between the pipeline and pc_gen.
// Latency: none, wires only.
// Backpressure: stall travels from master to slave; the bundle itself has no flow control.
//   master: drives redirect/call/ret/stall requests, observes pc, pc_valid and ras_count
//   slave : pc_gen side, consumes requests and produces the fetch PC
interface pc_gen_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic            stall;
    logic            exc_valid;
    logic [XLEN-1:0] exc_target;
    logic            br_valid;
    logic [XLEN-1:0] br_target;
    logic            call_valid;
    logic [XLEN-1:0] call_target;
    logic            ret_valid;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic [CW-1:0]   ras_count;

    modport master (
        output stall, exc_valid, exc_target, br_valid, br_target,
               call_valid, call_target, ret_valid,
        input  pc, pc_valid, ras_count
    );

    modport slave (
        input  stall, exc_valid, exc_target, br_valid, br_target,
               call_valid, call_target, ret_valid,
        output pc, pc_valid, ras_count
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator with post-reset hold and a circular return-address stack.
// Latency: one cycle from request sample to pc; pc/pc_valid are registered only.
// Backpressure: stall holds pc and blocks call/ret; exception and branch redirects still win.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pc_gen_if.slave (requests in; pc, pc_valid, ras_count out)
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INC          = 4,
    parameter int              RST_HOLD     = 2,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_gen_if.slave  bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(RST_HOLD + 1);

    logic [XLEN-1:0] pc_q;
    logic            vld_q;
    logic [HW-1:0]   hold_q;
    logic [PW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];

    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] ras_top;
    logic            ras_nonempty;
    logic            run_seq;
    logic            do_push;

    assign pc_inc       = pc_q + XLEN'(INC);
    // ptr_q points at the next free slot; the top entry sits one below (wraps).
    assign ras_top      = ras_mem[ptr_q - PW'(1)];
    assign ras_nonempty = (cnt_q != '0);
    // Sequencing rules below the redirect/stall tiers only apply in the run phase.
    assign run_seq      = vld_q & ~bus.exc_valid & ~bus.br_valid & ~bus.stall;
    // A concurrent ret always drops the call, even when the RAS is empty.
    assign do_push      = run_seq & ~bus.ret_valid & bus.call_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_VECTOR;
            vld_q  <= 1'b0;
            hold_q <= HW'(RST_HOLD);
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else if (!vld_q) begin
            // Hold phase: count down, then raise pc_valid one edge later with
            // pc still at RESET_VECTOR; sequencing starts on the edge after that.
            if (hold_q != '0) begin
                hold_q <= hold_q - HW'(1);
            end else begin
                vld_q <= 1'b1;
            end
        end else if (bus.exc_valid) begin
            pc_q  <= bus.exc_target;
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (bus.br_valid) begin
            pc_q <= bus.br_target;
        end else if (bus.stall) begin
            pc_q <= pc_q;
        end else if (bus.ret_valid) begin
            if (ras_nonempty) begin
                pc_q  <= ras_top;
                ptr_q <= ptr_q - PW'(1);
                cnt_q <= cnt_q - CW'(1);
            end else begin
                pc_q <= pc_inc;
            end
        end else if (bus.call_valid) begin
            pc_q  <= bus.call_target;
            ptr_q <= ptr_q + PW'(1);
            // When full the write above overwrote the oldest entry; count saturates.
            if (cnt_q != CW'(RAS_DEPTH)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else begin
            pc_q <= pc_inc;
        end
    end

    // Entry storage needs no reset: ras_count gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[ptr_q] <= pc_inc;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_valid  = vld_q;
    assign bus.ras_count = cnt_q;
endmodule
